// File: rtl/voice_allocator_pkg.sv
// ============================================================================
// Module   : voice_allocator_pkg
// Purpose  : Shared music definitions for the allocator and sample generator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package voice_allocator_pkg;

  localparam int NOTE_W             = 6;
  localparam int DUR_W              = 6;
  localparam int DEFAULT_NUM_VOICES = 4;
  localparam int DEFAULT_AGE_W      = 4;

  localparam logic [NOTE_W-1:0] REST_NOTE = '0;

endpackage

`default_nettype wire

// File: rtl/voice_allocator_voice_select.sv
// ============================================================================
// Module   : voice_select
// Purpose  : Picks the lowest free voice, else the oldest (lowest index on ties).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_select
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = DEFAULT_NUM_VOICES,
  parameter int AGE_W      = DEFAULT_AGE_W,
  parameter int IDX_W      = $clog2(NUM_VOICES)
) (
  input  logic [NUM_VOICES-1:0]       busy_mask,
  input  logic [NUM_VOICES*AGE_W-1:0] age_vec,
  output logic [IDX_W-1:0]            sel_idx,
  output logic                        any_free
);

  logic [IDX_W-1:0] w_free_idx;
  logic [IDX_W-1:0] w_old_idx;
  logic [AGE_W-1:0] w_old_age;
  logic             w_found;

  always_comb begin
    any_free   = ~&busy_mask;
    w_free_idx = '0;
    w_found    = 1'b0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (!busy_mask[i] && !w_found) begin
        w_found    = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end

    // Strict compare keeps the lowest index when ages tie.
    w_old_idx = '0;
    w_old_age = age_vec[AGE_W-1:0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_vec[i*AGE_W +: AGE_W] > w_old_age) begin
        w_old_age = age_vec[i*AGE_W +: AGE_W];
        w_old_idx = IDX_W'(i);
      end
    end

    sel_idx = any_free ? w_free_idx : w_old_idx;
  end

endmodule

`default_nettype wire

// File: rtl/voice_allocator.sv
// ============================================================================
// Module   : voice_allocator
// Purpose  : Steers song notes onto a pool of note players, stealing when full.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES  = DEFAULT_NUM_VOICES,
  parameter int NOTE_W      = voice_allocator_pkg::NOTE_W,
  parameter int DUR_W       = voice_allocator_pkg::DUR_W,
  parameter int AGE_W       = DEFAULT_AGE_W,
  parameter bit ALLOW_STEAL = 1'b1,
  parameter int CNT_W       = $clog2(NUM_VOICES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  play_enable,
  input  logic                  flush,
  input  logic                  beat,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [NOTE_W-1:0]     note_in,
  input  logic [DUR_W-1:0]      dur_in,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  output logic [NUM_VOICES-1:0] busy_mask,
  output logic [CNT_W-1:0]      active_count,
  output logic                  steal
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  logic [NUM_VOICES-1:0]       r_busy;
  logic [AGE_W-1:0]            r_age [NUM_VOICES];
  logic [NUM_VOICES*AGE_W-1:0] w_age_vec;
  logic [NUM_VOICES-1:0]       r_voice_load;
  logic [NOTE_W-1:0]           r_voice_note;
  logic [DUR_W-1:0]            r_voice_dur;
  logic                        r_steal;
  logic [IDX_W-1:0]            w_sel_idx;
  logic                        w_any_free;
  logic                        w_accept;
  logic                        w_alloc;
  logic [CNT_W-1:0]            w_count;

  for (genvar k = 0; k < NUM_VOICES; k++) begin : g_age_pack
    assign w_age_vec[k*AGE_W +: AGE_W] = r_age[k];
  end

  voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W),
    .IDX_W      (IDX_W)
  ) u_voice_select (
    .busy_mask (r_busy),
    .age_vec   (w_age_vec),
    .sel_idx   (w_sel_idx),
    .any_free  (w_any_free)
  );

  assign load_ready = play_enable & ~flush & (w_any_free | ALLOW_STEAL);
  assign w_accept   = load_valid & load_ready;
  // Rests are consumed from the song stream but never occupy a voice.
  assign w_alloc    = w_accept & (note_in != NOTE_W'(REST_NOTE));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy <= '0;
      for (int k = 0; k < NUM_VOICES; k++) r_age[k] <= '0;
    end else if (flush) begin
      r_busy <= '0;
      for (int k = 0; k < NUM_VOICES; k++) r_age[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_VOICES; k++) begin
        if (w_alloc && (w_sel_idx == IDX_W'(k))) begin
          r_busy[k] <= 1'b1;
          r_age[k]  <= '0;
        end else if (voice_done[k]) begin
          r_busy[k] <= 1'b0;
          r_age[k]  <= '0;
        end else if (beat && play_enable && r_busy[k] && (r_age[k] != '1)) begin
          r_age[k]  <= r_age[k] + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_voice_load <= '0;
      r_voice_note <= '0;
      r_voice_dur  <= '0;
      r_steal      <= 1'b0;
    end else if (flush) begin
      r_voice_load <= '0;
      r_steal      <= 1'b0;
    end else begin
      r_voice_load <= w_alloc ? (NUM_VOICES'(1) << w_sel_idx) : '0;
      r_steal      <= w_alloc & ~w_any_free;
      if (w_alloc) begin
        r_voice_note <= note_in;
        r_voice_dur  <= dur_in;
      end
    end
  end

  always_comb begin
    w_count = '0;
    for (int i = 0; i < NUM_VOICES; i++) w_count = w_count + CNT_W'(r_busy[i]);
  end

  assign voice_load     = r_voice_load;
  assign voice_note     = r_voice_note;
  assign voice_duration = r_voice_dur;
  assign steal          = r_steal;
  assign busy_mask      = r_busy;
  assign active_count   = w_count;

endmodule

`default_nettype wire

// File: tb/tb_voice_allocator.sv
// ============================================================================
// Module   : tb_voice_allocator
// Purpose  : Directed bench for voice_allocator (stealing and non-stealing copies).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_voice_allocator;

  logic       clk, reset, play_enable, flush, beat, load_valid;
  logic [5:0] note_in, dur_in;
  logic [3:0] voice_done;

  // Index 0: ALLOW_STEAL=1, index 1: ALLOW_STEAL=0
  logic       rdy   [2];
  logic [3:0] vld   [2];
  logic [5:0] vnote [2];
  logic [5:0] vdur  [2];
  logic [3:0] bmask [2];
  logic [2:0] acnt  [2];
  logic       stl   [2];

  int vectors = 0;
  int errors  = 0;

  voice_allocator #(.NUM_VOICES(4), .NOTE_W(6), .DUR_W(6), .AGE_W(4), .ALLOW_STEAL(1'b1)) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .flush(flush), .beat(beat),
    .load_valid(load_valid), .load_ready(rdy[0]), .note_in(note_in), .dur_in(dur_in),
    .voice_done(voice_done), .voice_load(vld[0]), .voice_note(vnote[0]),
    .voice_duration(vdur[0]), .busy_mask(bmask[0]), .active_count(acnt[0]), .steal(stl[0]));

  voice_allocator #(.NUM_VOICES(4), .NOTE_W(6), .DUR_W(6), .AGE_W(4), .ALLOW_STEAL(1'b0)) dut_ns (
    .clk(clk), .reset(reset), .play_enable(play_enable), .flush(flush), .beat(beat),
    .load_valid(load_valid), .load_ready(rdy[1]), .note_in(note_in), .dur_in(dur_in),
    .voice_done(voice_done), .voice_load(vld[1]), .voice_note(vnote[1]),
    .voice_duration(vdur[1]), .busy_mask(bmask[1]), .active_count(acnt[1]), .steal(stl[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_busy  [2][4];
  int         m_age   [2][4];
  logic [3:0] m_load  [2];
  logic [5:0] m_note  [2];
  logic [5:0] m_dur   [2];
  bit         m_steal [2];

  function automatic bit m_any_free(int m);
    for (int k = 0; k < 4; k++) if (!m_busy[m][k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_ready(int m);
    return play_enable && !flush && (m_any_free(m) || m == 0);
  endfunction

  function automatic int m_pick(int m);
    int best;
    for (int k = 0; k < 4; k++) if (!m_busy[m][k]) return k;
    best = 0;
    for (int k = 1; k < 4; k++) if (m_age[m][k] > m_age[m][best]) best = k;
    return best;
  endfunction

  function automatic logic [3:0] m_mask(int m);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < 4; k++) r[k] = m_busy[m][k];
    return r;
  endfunction

  function automatic int m_count(int m);
    int c;
    c = 0;
    for (int k = 0; k < 4; k++) c += int'(m_busy[m][k]);
    return c;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int m = 0; m < 2; m++) begin
        for (int k = 0; k < 4; k++) begin
          m_busy[m][k] = 1'b0;
          m_age[m][k]  = 0;
        end
        m_load[m] = '0; m_note[m] = '0; m_dur[m] = '0; m_steal[m] = 1'b0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        bit free, alloc;
        int sel;
        free  = m_any_free(m);
        alloc = load_valid && m_ready(m) && (note_in != 6'd0);
        sel   = m_pick(m);
        if (flush) begin
          for (int k = 0; k < 4; k++) begin
            m_busy[m][k] = 1'b0;
            m_age[m][k]  = 0;
          end
          m_load[m]  = '0;
          m_steal[m] = 1'b0;
        end else begin
          for (int k = 0; k < 4; k++) begin
            if (voice_done[k]) begin
              m_busy[m][k] = 1'b0;
              m_age[m][k]  = 0;
            end else if (beat && play_enable && m_busy[m][k]) begin
              m_age[m][k] = (m_age[m][k] + 1 > 15) ? 15 : m_age[m][k] + 1;
            end
          end
          if (alloc) begin
            m_busy[m][sel] = 1'b1;
            m_age[m][sel]  = 0;
            m_note[m]      = note_in;
            m_dur[m]       = dur_in;
          end
          m_load[m]  = alloc ? (4'b0001 << sel) : 4'b0000;
          m_steal[m] = alloc && !free;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("u%0d load_ready", m), rdy[m], m_ready(m));
      chk($sformatf("u%0d voice_load", m), vld[m], m_load[m]);
      chk($sformatf("u%0d voice_note", m), vnote[m], m_note[m]);
      chk($sformatf("u%0d voice_duration", m), vdur[m], m_dur[m]);
      chk($sformatf("u%0d busy_mask", m), bmask[m], m_mask(m));
      chk($sformatf("u%0d active_count", m), acnt[m], m_count(m));
      chk($sformatf("u%0d steal", m), stl[m], m_steal[m]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; flush = 1'b0; beat = 1'b0;
    voice_done = '0; play_enable = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic beats(input int n);
    repeat (n) begin
      beat = 1'b1; tick();
      beat = 1'b0; tick();
    end
  endtask

  task automatic load(input logic [5:0] n, input logic [5:0] d);
    load_valid = 1'b1; note_in = n; dur_in = d;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; play_enable = 1'b0; flush = 1'b0; beat = 1'b0;
    load_valid = 1'b0; note_in = '0; dur_in = '0; voice_done = '0;
    tick();
    chk("reset busy_mask", bmask[0], 4'b0000);
    chk("reset voice_load", vld[0], 4'b0000);
    chk("reset active_count", acnt[0], 0);
    reset = 1'b0;

    // back-to-back allocation to the lowest free voices
    do_reset();
    load_valid = 1'b1; note_in = 6'd10; dur_in = 6'd3;
    tick(); chk("t1 load0", vld[0], 4'b0001); chk("t1 note0", vnote[0], 10);
    note_in = 6'd11;
    tick(); chk("t1 load1", vld[0], 4'b0010);
    note_in = 6'd12;
    tick(); chk("t1 load2", vld[0], 4'b0100);
    load_valid = 1'b0;
    tick(); chk("t1 busy", bmask[0], 4'b0111); chk("t1 count", acnt[0], 3);
    chk("t1 idle strobe", vld[0], 4'b0000);

    // ages {3,7,7,2}: steal goes to voice 1
    do_reset();
    load(6'd1, 6'd1); load(6'd2, 6'd1); load(6'd3, 6'd1);
    beats(4);
    voice_done = 4'b0001; tick(); voice_done = '0;
    load(6'd4, 6'd1);
    beats(1);
    load(6'd5, 6'd1);
    beats(2);
    load_valid = 1'b1; note_in = 6'd20; dur_in = 6'd4;
    #1;
    chk("t2 ready steal", rdy[0], 1'b1);
    chk("t3 ready nosteal full", rdy[1], 1'b0);
    tick();
    chk("t2 steal load", vld[0], 4'b0010); chk("t2 steal", stl[0], 1'b1);
    chk("t2 busy", bmask[0], 4'b1111);
    tick(); chk("t3 held ready a", rdy[1], 1'b0);
    tick(); chk("t3 held ready b", rdy[1], 1'b0);
    voice_done = 4'b0100;
    #1; chk("t3 done not visible", rdy[1], 1'b0);
    tick(); voice_done = '0;
    chk("t3 ready after done", rdy[1], 1'b1);
    tick(); load_valid = 1'b0;
    chk("t3 nosteal load", vld[1], 4'b0100); chk("t3 nosteal steal", stl[1], 1'b0);

    // done and allocation on voice 0 in the same cycle, then a rest
    do_reset();
    load(6'd1, 6'd1); load(6'd2, 6'd1); load(6'd3, 6'd1);
    beats(2);
    load(6'd4, 6'd1);
    load_valid = 1'b1; note_in = 6'd30; dur_in = 6'd7; voice_done = 4'b0001;
    tick(); load_valid = 1'b0; voice_done = '0;
    chk("t4 load v0", vld[0], 4'b0001); chk("t4 steal", stl[0], 1'b1);
    chk("t4 busy", bmask[0], 4'b1111);
    load(6'd0, 6'd5);
    chk("t4 rest no load", vld[0], 4'b0000); chk("t4 rest busy", bmask[0], 4'b1111);
    chk("t4 rest count", acnt[0], 4); chk("t4 note hold", vnote[0], 30);

    // saturation: voice 0 at 15 beats out-ages voices at 8
    do_reset();
    load(6'd7, 6'd9);
    beats(12);
    load(6'd1, 6'd1); load(6'd2, 6'd1); load(6'd3, 6'd1);
    beats(8);
    play_enable = 1'b0;
    beats(5);
    load_valid = 1'b1; note_in = 6'd40; dur_in = 6'd2;
    #1; chk("t5 paused ready", rdy[0], 1'b0);
    play_enable = 1'b1;
    #1; chk("t5 resumed ready", rdy[0], 1'b1);
    tick(); load_valid = 1'b0;
    chk("t5 steal oldest", vld[0], 4'b0001); chk("t5 steal", stl[0], 1'b1);

    // flush during a strobe, then async reset during a strobe
    do_reset();
    load(6'd50, 6'd2);
    chk("t6 strobe", vld[0], 4'b0001);
    flush = 1'b1; load_valid = 1'b1; note_in = 6'd51;
    #1; chk("t6 flush ready", rdy[0], 1'b0);
    tick(); flush = 1'b0; load_valid = 1'b0;
    chk("t6 flush busy", bmask[0], 4'b0000); chk("t6 flush load", vld[0], 4'b0000);
    chk("t6 flush steal", stl[0], 1'b0); chk("t6 flush count", acnt[0], 0);
    load(6'd52, 6'd2);
    chk("t6 strobe2", vld[0], 4'b0001);
    #1 reset = 1'b1;
    #1;
    chk("t6 async load", vld[0], 4'b0000); chk("t6 async busy", bmask[0], 4'b0000);
    chk("t6 async note", vnote[0], 0);
    tick(); reset = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
